// File: rtl/niosmp_nios2_processor_oci_dct_packer.sv
// Trace atom packer: gathers 2-bit atoms into 15-atom words for the DCT buffer.
// Ports: clk, reset (sync, active-high); atom_valid/atom/atom_ready in;
//   flush_req, end_req controls; dct_buffer/dct_count/dct_valid/dct_ready out;
//   test_ending (1-cycle pulse), test_has_ended (sticky).
module niosmp_nios2_processor_oci_dct_packer #(
  parameter int IDLE_FLUSH = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  output logic        atom_ready,
  input  logic        flush_req,
  input  logic        end_req,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        dct_valid,
  input  logic        dct_ready,
  output logic        test_ending,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    ENDING,
    ENDED
  } state_t;

  localparam int IW = $clog2(IDLE_FLUSH + 2);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_FLUSH);

  state_t state;
  state_t state_d;

  logic [29:0]   acc;
  logic [29:0]   acc_ins;
  logic [29:0]   mask;
  logic [3:0]    acc_cnt;
  logic          flush_pend;
  logic [IW-1:0] idle_cnt;

  logic out_free;
  logic idle_hit;
  logic want;
  logic xfer;
  logic accept;

  assign out_free = !dct_valid || dct_ready;
  assign idle_hit = (IDLE_FLUSH != 0) && (idle_cnt == IDLE_MAX);
  assign want     = (acc_cnt == 4'd15) || flush_pend || idle_hit
                 || (state == DRAIN);
  assign xfer     = (acc_cnt != 4'd0) && out_free && want;

  assign atom_ready = (state == RUN) && ((acc_cnt < 4'd15) || xfer);
  assign accept     = atom_valid && atom_ready;

  // Mask keeps only the atoms actually collected; shift of 30 wraps to
  // zero so a full word yields an all-ones mask.
  assign mask = (30'd1 << {acc_cnt, 1'b0}) - 30'd1;

  always_comb begin
    acc_ins = acc;
    acc_ins[{acc_cnt, 1'b0} +: 2] = atom;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
    end else begin
      if (xfer) begin
        dct_buffer <= acc & mask;
        dct_count  <= acc_cnt;
        dct_valid  <= 1'b1;
      end else if (dct_ready) begin
        dct_valid  <= 1'b0;
      end

      // An atom taken in the transfer cycle opens the next word.
      if (xfer) begin
        acc     <= accept ? {28'd0, atom} : 30'd0;
        acc_cnt <= accept ? 4'd1 : 4'd0;
      end else if (accept) begin
        acc     <= acc_ins;
        acc_cnt <= acc_cnt + 4'd1;
      end

      // Flush on an empty accumulator is dropped so no empty word is sent.
      if (xfer || (acc_cnt == 4'd0)) begin
        flush_pend <= 1'b0;
      end else if (flush_req && (state == RUN)) begin
        flush_pend <= 1'b1;
      end

      if (accept || xfer) begin
        idle_cnt <= '0;
      end else if ((acc_cnt != 4'd0) && (idle_cnt != IDLE_MAX)) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d        = state;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    unique case (state)
      RUN: begin
        if (end_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Done once nothing is buffered and the last word leaves or is gone.
        if ((acc_cnt == 4'd0) && out_free) begin
          state_d = ENDING;
        end
      end
      ENDING: begin
        test_ending = 1'b1;
        state_d     = ENDED;
      end
      ENDED: begin
        test_has_ended = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

endmodule
